riscv_uart_boot_loader: RTL and testbench
=========================================

RISCV_UART_BOOT_LOADER -- requirements
Module: riscv_uart_boot_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit (100 MHz / 115200).
REQ-002 Parameter ADDR_WIDTH, default 10, instruction-memory word-address width (1024 words).
REQ-003 clk  input  1  sole clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 uartRx  input  1  asynchronous UART receive line, idle high, 8N1.
REQ-006 romWriteEnable  output  1  one-cycle write strobe to instruction memory.
REQ-007 romWriteAddress  output  ADDR_WIDTH  word address of current write.
REQ-008 romWriteData  output  32  word to write.
REQ-009 cpuReset  output  1  hold for the 5-stage datapath; 1 = CPU held in reset.
REQ-010 loadDone  output  1  image fully written; sticky until rst.
REQ-011 loadError  output  1  load aborted; sticky until rst.

Function
REQ-012 uartRx SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Receiver: falling edge of synchronized line in RX idle starts a frame; start bit re-sampled at CLKS_PER_BIT/2 (integer division), low = valid, high = glitch, return to RX idle.
REQ-014 Receiver: 8 data bits sampled LSB first, each CLKS_PER_BIT cycles after the previous sample; stop bit sampled likewise.
REQ-015 Receiver: stop bit 1 -> one-cycle byteValid with byte; stop bit 0 -> one-cycle framingError, no byteValid.
REQ-016 Protocol: byte 0 = count[7:0], byte 1 = count[15:8], then count words, each 4 bytes little-endian (first byte -> bits 7:0).
REQ-017 Loader FSM states: COUNT_LO, COUNT_HI, DATA, DONE, ERROR; reset state COUNT_LO.
REQ-018 COUNT_LO -> COUNT_HI on byteValid; COUNT_HI -> DATA on byteValid when 1 <= count <= 2^ADDR_WIDTH, else -> ERROR.
REQ-019 In DATA, every 4th byte SHALL drive romWriteEnable=1 for exactly the next cycle with romWriteData = assembled word and romWriteAddress = word index, starting at 0, incrementing by 1 after each write.
REQ-020 romWriteAddress/romWriteData SHALL hold their last values when romWriteEnable=0.
REQ-021 Cycle after the write strobe of word count-1: state DONE, loadDone=1, cpuReset=0.
REQ-022 framingError in COUNT_LO, COUNT_HI or DATA -> ERROR; partial word discarded, no write.
REQ-023 ERROR: loadError=1, cpuReset=1, no further writes; exit only via rst.
REQ-024 DONE: cpuReset=0 and loadDone=1 held; further bytes or framing errors ignored, no writes.
REQ-025 cpuReset SHALL be 1 in every state except DONE; loadDone and loadError never both 1.
REQ-026 Word index counter SHALL be ADDR_WIDTH+1 bits so count = 2^ADDR_WIDTH completes without wrap.

Reset
REQ-027 On rst=1 at a clock edge: romWriteEnable=0, romWriteAddress=0, romWriteData=0, cpuReset=1, loadDone=0, loadError=0, FSM=COUNT_LO, receiver idle, byte/word counters 0.
REQ-028 rst mid-frame or mid-image SHALL abort fully; the next load restarts at COUNT_LO, address 0.

Structure
REQ-029 Shared package: loader FSM state encoding, receiver state encoding, protocol constants (header length 2, bytes per word 4).
REQ-030 One sub-module uart_byte_receiver (synchronizer, bit timing, byteValid/framingError); loader FSM and word assembly in top.
REQ-031 Top SHALL drive the instruction-memory write port and the datapath reset directly; no memory instantiated inside.

Verification (CLKS_PER_BIT=8, ADDR_WIDTH=4)
REQ-032 Send 02 00, EF BE AD DE, 78 56 34 12 -> writes (0,0xDEADBEEF), (1,0x12345678), one strobe each; next cycle loadDone=1, cpuReset=0.
REQ-033 Send 00 00 -> loadError=1, cpuReset=1, zero writes.
REQ-034 Send 11 00 (17 > 16) -> loadError=1; send 10 00 plus 64 bytes -> 16 writes, last address 15, loadDone=1.
REQ-035 Send 01 00, AA, BB then frame with stop bit 0 -> loadError=1, no write.
REQ-036 3-cycle low glitch on uartRx while idle -> no byteValid, FSM unchanged; after DONE send 55 -> no write, outputs unchanged.
REQ-037 rst asserted after 2 of 4 data bytes -> all outputs reset values; fresh 01 00 78 56 34 12 -> write (0,0x12345678), loadDone=1.

Source files
------------

// File: rtl/riscv_uart_boot_loader_pkg.sv
// Shared encodings and protocol constants for the UART boot loader and its byte receiver.
package riscv_uart_boot_loader_pkg;

    typedef enum logic [2:0] {
        COUNT_LO,
        COUNT_HI,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int HEADER_BYTES   = 2;
    localparam int BYTES_PER_WORD = 4;

    // An image must hold at least one word and must fit the instruction memory.
    function automatic logic count_in_range(input logic [15:0] count, input int addr_width);
        return (count != 16'd0) && (32'(count) <= (32'd1 << addr_width));
    endfunction

endpackage

// File: rtl/riscv_uart_boot_loader_uart_rx.sv
// 8N1 UART byte receiver: input synchronizer, mid-bit sampling, byte/framing-error strobes.
module uart_byte_receiver
    import riscv_uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uartRx,
    output logic       byteValid,
    output logic [7:0] rxByte,
    output logic       framingError
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            state        <= RX_IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rxByte       <= '0;
            byteValid    <= 1'b0;
            framingError <= 1'b0;
        end else begin
            rx_meta      <= uartRx;
            rx_sync      <= rx_meta;
            rx_prev      <= rx_sync;
            byteValid    <= 1'b0;
            framingError <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state   <= RX_START;
                        clk_cnt <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= RX_IDLE;
                        if (rx_sync) begin
                            byteValid <= 1'b1;
                            rxByte    <= shift;
                        end else begin
                            framingError <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/riscv_uart_boot_loader.sv
// UART boot loader: receives a word-count header and little-endian words, writes them to
// instruction memory and releases the CPU reset once the whole image has landed.
module riscv_uart_boot_loader
    import riscv_uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uartRx,
    output logic                  romWriteEnable,
    output logic [ADDR_WIDTH-1:0] romWriteAddress,
    output logic [31:0]           romWriteData,
    output logic                  cpuReset,
    output logic                  loadDone,
    output logic                  loadError
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic                byte_valid;
    logic [7:0]          rx_byte;
    logic                framing_error;

    loader_state_t       state;
    logic [7:0]          count_lo;
    logic [15:0]         word_count;
    logic [1:0]          byte_idx;
    logic [23:0]         word_buf;
    logic [ADDR_WIDTH:0] word_idx;
    logic [16:0]         word_idx_ext;
    logic [16:0]         word_count_ext;

    assign word_idx_ext   = 17'(word_idx);
    assign word_count_ext = 17'(word_count);

    uart_byte_receiver #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .uartRx      (uartRx),
        .byteValid   (byte_valid),
        .rxByte      (rx_byte),
        .framingError(framing_error)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= COUNT_LO;
            count_lo        <= '0;
            word_count      <= '0;
            byte_idx        <= '0;
            word_buf        <= '0;
            word_idx        <= '0;
            romWriteEnable  <= 1'b0;
            romWriteAddress <= '0;
            romWriteData    <= '0;
            cpuReset        <= 1'b1;
            loadDone        <= 1'b0;
            loadError       <= 1'b0;
        end else begin
            romWriteEnable <= 1'b0;
            case (state)
                COUNT_LO: begin
                    if (framing_error) begin
                        state     <= ERROR;
                        loadError <= 1'b1;
                    end else if (byte_valid) begin
                        count_lo <= rx_byte;
                        state    <= COUNT_HI;
                    end
                end
                COUNT_HI: begin
                    if (framing_error) begin
                        state     <= ERROR;
                        loadError <= 1'b1;
                    end else if (byte_valid) begin
                        word_count <= {rx_byte, count_lo};
                        if (count_in_range({rx_byte, count_lo}, ADDR_WIDTH)) begin
                            state <= DATA;
                        end else begin
                            state     <= ERROR;
                            loadError <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    // word_idx has already advanced past the word being strobed this cycle.
                    if (romWriteEnable && word_idx_ext == word_count_ext) begin
                        state    <= DONE;
                        loadDone <= 1'b1;
                        cpuReset <= 1'b0;
                    end else if (framing_error) begin
                        state     <= ERROR;
                        loadError <= 1'b1;
                    end else if (byte_valid) begin
                        if (byte_idx == LAST_BYTE) begin
                            romWriteEnable  <= 1'b1;
                            romWriteData    <= {rx_byte, word_buf};
                            romWriteAddress <= word_idx[ADDR_WIDTH-1:0];
                            word_idx        <= word_idx + 1'b1;
                            byte_idx        <= '0;
                        end else begin
                            word_buf <= {rx_byte, word_buf[23:8]};
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                end
                default: begin
                    state     <= ERROR;
                    loadError <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_uart_boot_loader.sv
// Self-checking bench: serial stimulus against a byte-level protocol model of the boot loader.
module tb_riscv_uart_boot_loader;

    localparam int CPB = 8;
    localparam int AW  = 4;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          uartRx = 1'b1;
    logic          romWriteEnable;
    logic [AW-1:0] romWriteAddress;
    logic [31:0]   romWriteData;
    logic          cpuReset;
    logic          loadDone;
    logic          loadError;

    riscv_uart_boot_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .uartRx         (uartRx),
        .romWriteEnable (romWriteEnable),
        .romWriteAddress(romWriteAddress),
        .romWriteData   (romWriteData),
        .cpuReset       (cpuReset),
        .loadDone       (loadDone),
        .loadError      (loadError)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tx_bytes[$];
    bit          tx_stop[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          log_addr[$];
    logic [31:0] log_data[$];
    bit          exp_done;
    bit          exp_err;
    int          exp_nwrites;
    bit          pending_done;
    bit          done_reached;
    logic [AW-1:0] last_addr;
    logic [31:0]   last_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Protocol-level model: what a full load of tx_bytes must produce.
    task automatic model_compute();
        int cnt   = 0;
        int words = 0;
        logic [31:0] w = '0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < tx_bytes.size(); i++) begin
            if (exp_done || exp_err) begin
            end else if (!tx_stop[i]) begin
                exp_err = 1'b1;
            end else if (i == 0) begin
                cnt = int'(tx_bytes[i]);
            end else if (i == 1) begin
                cnt = cnt + 256 * int'(tx_bytes[i]);
                if (cnt < 1 || cnt > (1 << AW)) exp_err = 1'b1;
            end else begin
                int pos;
                pos = (i - 2) % 4;
                w[8*pos +: 8] = tx_bytes[i];
                if (pos == 3) begin
                    exp_addr.push_back(words);
                    exp_data.push_back(w);
                    words++;
                    if (words == cnt) exp_done = 1'b1;
                end
            end
        end
        exp_nwrites = words;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        uartRx = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        log_addr.delete();
        log_data.delete();
        pending_done = 1'b0;
        done_reached = 1'b0;
        last_addr    = '0;
        last_data    = '0;
        exp_done     = 1'b0;
        exp_err      = 1'b0;
        exp_nwrites  = 0;
        repeat (2) @(negedge clk);
        check("rst_romWriteEnable", 32'(romWriteEnable), 32'd0);
        check("rst_romWriteAddress", 32'(romWriteAddress), 32'd0);
        check("rst_romWriteData", romWriteData, 32'd0);
        check("rst_cpuReset", 32'(cpuReset), 32'd1);
        check("rst_loadDone", 32'(loadDone), 32'd0);
        check("rst_loadError", 32'(loadError), 32'd0);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uartRx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uartRx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uartRx = stop_ok;
        repeat (CPB) @(negedge clk);
        uartRx = 1'b1;
        repeat ($urandom_range(2, 12)) @(negedge clk);
    endtask

    task automatic glitch();
        uartRx = 1'b0;
        repeat (3) @(negedge clk);
        uartRx = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b, input bit s);
        tx_bytes.push_back(b);
        tx_stop.push_back(s);
    endtask

    task automatic tx_clear();
        tx_bytes.delete();
        tx_stop.delete();
    endtask

    task automatic run_load(input bit with_glitch);
        do_reset();
        model_compute();
        for (int i = 0; i < tx_bytes.size(); i++) begin
            if (with_glitch) glitch();
            send_byte(tx_bytes[i], tx_stop[i]);
        end
        if (with_glitch) glitch();
        repeat (30) @(negedge clk);
        check("final_loadDone", 32'(loadDone), 32'(exp_done));
        check("final_loadError", 32'(loadError), 32'(exp_err));
        check("final_cpuReset", 32'(cpuReset), 32'(!exp_done));
        check("missing_writes", 32'(exp_data.size()), 32'd0);
        check("write_count", 32'(log_data.size()), 32'(exp_nwrites));
    endtask

    // Per-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (pending_done) begin
                done_reached = 1'b1;
                pending_done = 1'b0;
            end
            check("loadDone", 32'(loadDone), 32'(done_reached));
            check("cpuReset", 32'(cpuReset), 32'(!done_reached));
            check("loadError_allowed", 32'(loadError & ~exp_err), 32'd0);
            check("done_err_exclusive", 32'(loadDone & loadError), 32'd0);
            if (romWriteEnable) begin
                if (exp_data.size() == 0) begin
                    check("unexpected_write", 32'(romWriteEnable), 32'd0);
                end else begin
                    int          ea;
                    logic [31:0] ed;
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    check("write_addr", 32'(romWriteAddress), 32'(ea));
                    check("write_data", romWriteData, ed);
                    if (exp_data.size() == 0 && exp_done) pending_done = 1'b1;
                end
                log_addr.push_back(int'(romWriteAddress));
                log_data.push_back(romWriteData);
                last_addr = romWriteAddress;
                last_data = romWriteData;
            end else begin
                check("addr_hold", 32'(romWriteAddress), 32'(last_addr));
                check("data_hold", romWriteData, last_data);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Two-word image with idle glitches, then a stray byte after completion.
        begin
            logic [7:0] seq[11] = '{8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                    8'h78, 8'h56, 8'h34, 8'h12, 8'h55};
            tx_clear();
            foreach (seq[i]) push(seq[i], 1'b1);
        end
        run_load(1'b1);
        check("lit_w0_addr", 32'(log_addr[0]), 32'd0);
        check("lit_w0_data", log_data[0], 32'hDEADBEEF);
        check("lit_w1_addr", 32'(log_addr[1]), 32'd1);
        check("lit_w1_data", log_data[1], 32'h12345678);
        check("lit_done", 32'(loadDone), 32'd1);

        // Zero count, followed by bytes that must be ignored.
        tx_clear();
        push(8'h00, 1'b1); push(8'h00, 1'b1);
        push(8'hAA, 1'b1); push(8'hBB, 1'b1); push(8'hCC, 1'b1); push(8'hDD, 1'b1);
        run_load(1'b0);
        check("lit_zero_err", 32'(loadError), 32'd1);
        check("lit_zero_writes", 32'(log_data.size()), 32'd0);

        // Count one beyond memory depth.
        tx_clear();
        push(8'h11, 1'b1); push(8'h00, 1'b1);
        run_load(1'b0);
        check("lit_over_err", 32'(loadError), 32'd1);

        // Full-depth image.
        tx_clear();
        push(8'h10, 1'b1); push(8'h00, 1'b1);
        for (int i = 0; i < 64; i++) push(8'($urandom_range(0, 255)), 1'b1);
        run_load(1'b0);
        check("lit_full_count", 32'(log_data.size()), 32'd16);
        check("lit_full_last_addr", 32'(log_addr[15]), 32'd15);
        check("lit_full_done", 32'(loadDone), 32'd1);

        // Framing error inside a partial word.
        tx_clear();
        push(8'h01, 1'b1); push(8'h00, 1'b1); push(8'hAA, 1'b1); push(8'hBB, 1'b1);
        push(8'hCC, 1'b0);
        run_load(1'b0);
        check("lit_frame_err", 32'(loadError), 32'd1);
        check("lit_frame_writes", 32'(log_data.size()), 32'd0);

        // Reset half way through a word, then a fresh load.
        tx_clear();
        push(8'h01, 1'b1); push(8'h00, 1'b1); push(8'h78, 1'b1); push(8'h56, 1'b1);
        run_load(1'b0);
        tx_clear();
        push(8'h01, 1'b1); push(8'h00, 1'b1);
        push(8'h78, 1'b1); push(8'h56, 1'b1); push(8'h34, 1'b1); push(8'h12, 1'b1);
        run_load(1'b0);
        check("lit_restart_addr", 32'(log_addr[0]), 32'd0);
        check("lit_restart_data", log_data[0], 32'h12345678);

        // Randomized loads: valid images, bad counts, stray framing errors, trailing bytes.
        for (int r = 0; r < 8; r++) begin
            int cnt;
            int mode;
            int nbytes;
            int errpos;
            cnt  = $urandom_range(1, 6);
            mode = $urandom_range(0, 9);
            if (mode == 0) cnt = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 300);
            tx_clear();
            push(8'(cnt), 1'b1);
            push(8'(cnt >> 8), 1'b1);
            nbytes = (cnt >= 1 && cnt <= 16) ? 4 * cnt + $urandom_range(0, 3) : 2;
            for (int j = 0; j < nbytes; j++) push(8'($urandom_range(0, 255)), 1'b1);
            if (mode == 1) begin
                errpos = $urandom_range(0, tx_stop.size() - 1);
                tx_stop[errpos] = 1'b0;
            end
            run_load(r[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
